// File: rtl/mplier_arbiter.sv
// ============================================================================
// Module   : mplier_arbiter
// Purpose  : Round-robin sharing of one signed 32x32 multiplier among NUM_REQ
//            requesters; two-stage issue/result pipeline with backpressure.
//            Optional perf counters: define MPLIER_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mplier_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_mplier,
    input  logic [NUM_REQ*32-1:0]    req_mcand,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_product,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     busy
`ifdef MPLIER_ARB_PERF_EN
    ,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_stall
`endif
);

    logic [31:0]      w_mplier_arr [NUM_REQ];
    logic [31:0]      w_mcand_arr  [NUM_REQ];
    logic [TAG_W-1:0] w_tag_arr    [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_mplier_arr[gi] = req_mplier[gi*32 +: 32];
        assign w_mcand_arr[gi]  = req_mcand[gi*32 +: 32];
        assign w_tag_arr[gi]    = req_tag[gi*TAG_W +: TAG_W];
    end

    logic             r_s1_v;
    logic [31:0]      r_s1_mplier;
    logic [31:0]      r_s1_mcand;
    logic [ID_W-1:0]  r_s1_id;
    logic [TAG_W-1:0] r_s1_tag;
    logic [ID_W-1:0]  r_rr_ptr;

    logic             r_rsp_valid;
    logic [63:0]      r_rsp_product;
    logic [ID_W-1:0]  r_rsp_id;
    logic [TAG_W-1:0] r_rsp_tag;

    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_s1_free;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_id;
    logic             w_grant_any;
    logic [ID_W-1:0]  w_scan_idx;
    logic [ID_W-1:0]  w_next_ptr;
    logic [63:0]      w_product;

    assign w_s2_free = !r_rsp_valid || rsp_ready;
    assign w_s1_adv  = r_s1_v && w_s2_free;
    assign w_s1_free = !r_s1_v || w_s1_adv;

    // Scan from the pointer upward; reset also forces the grant off.
    always_comb begin
        w_grant     = '0;
        w_grant_id  = '0;
        w_grant_any = 1'b0;
        w_scan_idx  = '0;
        if (w_s1_free && rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
                if (!w_grant_any && req_valid[w_scan_idx]) begin
                    w_grant_any          = 1'b1;
                    w_grant_id           = w_scan_idx;
                    w_grant[w_scan_idx]  = 1'b1;
                end
            end
        end
    end

    assign req_ready  = w_grant;
    assign w_next_ptr = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

    mplier32x32 u_mplier (
        .mplier  (r_s1_mplier),
        .mcand   (r_s1_mcand),
        .product (w_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v        <= 1'b0;
            r_s1_mplier   <= '0;
            r_s1_mcand    <= '0;
            r_s1_id       <= '0;
            r_s1_tag      <= '0;
            r_rr_ptr      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_product <= '0;
            r_rsp_id      <= '0;
            r_rsp_tag     <= '0;
        end else begin
            if (w_grant_any) begin
                r_s1_v      <= 1'b1;
                r_s1_mplier <= w_mplier_arr[w_grant_id];
                r_s1_mcand  <= w_mcand_arr[w_grant_id];
                r_s1_tag    <= w_tag_arr[w_grant_id];
                r_s1_id     <= w_grant_id;
                r_rr_ptr    <= w_next_ptr;
            end else if (w_s1_adv) begin
                r_s1_v <= 1'b0;
            end

            if (w_s1_adv) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_product <= w_product;
                r_rsp_id      <= r_s1_id;
                r_rsp_tag     <= r_s1_tag;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_product = r_rsp_product;
    assign rsp_id      = r_rsp_id;
    assign rsp_tag     = r_rsp_tag;
    assign busy        = r_s1_v || r_rsp_valid;

`ifdef MPLIER_ARB_PERF_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (|req_valid) && !(|w_grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_grant_any) r_perf_issued <= r_perf_issued + 32'd1;
            if (w_stall)     r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

endmodule

// Shared combinational signed multiplier datapath.
module mplier32x32 (
    input  logic [31:0] mplier,
    input  logic [31:0] mcand,
    output logic [63:0] product
);
    assign product = $signed({{32{mplier[31]}}, mplier}) * $signed({{32{mcand[31]}}, mcand});
endmodule

`default_nettype wire

// File: tb/tb_mplier_arbiter.sv
// ============================================================================
// Module   : tb_mplier_arbiter
// Purpose  : Randomized scoreboard bench for mplier_arbiter with directed
//            corner products, round-robin, backpressure and reset checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mplier_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TAG_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*32-1:0]    req_mplier;
    logic [NUM_REQ*32-1:0]    req_mcand;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [63:0]              rsp_product;
    logic [ID_W-1:0]          rsp_id;
    logic [TAG_W-1:0]         rsp_tag;
    logic                     busy;
`ifdef MPLIER_ARB_PERF_EN
    logic [31:0]              perf_issued;
    logic [31:0]              perf_stall;
`endif

    mplier_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mplier  (req_mplier),
        .req_mcand   (req_mcand),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .rsp_tag     (rsp_tag),
        .busy        (busy)
`ifdef MPLIER_ARB_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        int          id;
        int          tag;
        int          rdy;
    } ent_t;

    ent_t mdl[$];
    ent_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   ptr   = 0;
    int   acc_cnt = 0;
    longint m_issued = 0;
    longint m_stall  = 0;
    logic prev_rst = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] rr_pick(input int p, input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] g;
        g = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) begin
                g[(p + k) % NUM_REQ] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb2;
        sa  = a;
        sb2 = b;
        return 64'(longint'(sa) * longint'(sb2));
    endfunction

    // Reference model: in-flight list with earliest presentation cycle.
    always @(negedge clk) begin
        logic               exp_v;
        logic               hs;
        logic               s1_free;
        logic [NUM_REQ-1:0] g;
        ent_t               e;
        cyc++;
        if (!rst_n) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            mdl.delete();
            sb.delete();
            ptr      = 0;
            m_issued = 0;
            m_stall  = 0;
        end else begin
            if (!prev_rst) begin
                chk("reset_product", rsp_product, 64'd0);
                chk("reset_id", 64'(rsp_id), 64'd0);
                chk("reset_tag", 64'(rsp_tag), 64'd0);
            end
            exp_v = (mdl.size() > 0) && (mdl[0].rdy <= cyc);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            chk("busy", 64'(busy), 64'(mdl.size() > 0));
            hs      = exp_v && rsp_ready;
            s1_free = (mdl.size() < 2) || hs;
            g       = s1_free ? rr_pick(ptr, req_valid) : '0;
            chk("req_ready", 64'(req_ready), 64'(g));
`ifdef MPLIER_ARB_PERF_EN
            chk("perf_issued", 64'(perf_issued), 64'(m_issued % 64'h1_0000_0000));
            chk("perf_stall", 64'(perf_stall), 64'(m_stall % 64'h1_0000_0000));
`endif
            if (hs) begin
                void'(mdl.pop_front());
                if (mdl.size() > 0 && mdl[0].rdy < cyc + 1) mdl[0].rdy = cyc + 1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (g[i]) begin
                    e.prod = smul(req_mplier[i*32 +: 32], req_mcand[i*32 +: 32]);
                    e.id   = i;
                    e.tag  = int'(req_tag[i*TAG_W +: TAG_W]);
                    e.rdy  = cyc + 2;
                    mdl.push_back(e);
                    sb.push_back(e);
                    ptr = (i + 1) % NUM_REQ;
                    m_issued++;
                end
            end
            if ((|req_valid) && (g == '0)) m_stall++;
        end
        prev_rst = rst_n;
    end

    // Monitor: pops the scoreboard on every response handshake.
    logic        mon_hold = 1'b0;
    logic [63:0] mon_prod;
    logic [ID_W-1:0]  mon_id;
    logic [TAG_W-1:0] mon_tag;

    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            mon_hold = 1'b0;
        end else begin
            if (mon_hold) begin
                chk("stall_product", rsp_product, mon_prod);
                chk("stall_id", 64'(rsp_id), 64'(mon_id));
                chk("stall_tag", 64'(rsp_tag), 64'(mon_tag));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("product", rsp_product, e.prod);
                    chk("id", 64'(rsp_id), 64'(e.id));
                    chk("tag", 64'(rsp_tag), 64'(e.tag));
                end
            end
            mon_hold = rsp_valid && !rsp_ready;
            mon_prod = rsp_product;
            mon_id   = rsp_id;
            mon_tag  = rsp_tag;
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tg);
        req_mplier[i*32 +: 32]     = a;
        req_mcand[i*32 +: 32]      = b;
        req_tag[i*TAG_W +: TAG_W]  = tg;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Requesters hold valid/data until accepted, then optionally reissue.
    task automatic run(input int cycles, input int pvalid, input int pready,
                       input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] acc;
        repeat (cycles) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            acc_cnt += $countones(acc);
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = mask[i] && ($urandom_range(0, 99) < pvalid);
                    if (req_valid[i])
                        set_req(i, rand_op(), rand_op(), TAG_W'($urandom()));
                end
            end
            rsp_ready = ($urandom_range(0, 99) < pready);
        end
    endtask

    task automatic single(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tg, input logic [63:0] exp);
        int k;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        set_req(id, a, b, tg);
        req_valid[id] = 1'b1;
        k = 0;
        @(negedge clk);
        while (!req_ready[id] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[id]) begin
            chk("accept_timeout", 64'd1, 64'd0);
            return;
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        k = 1;
        @(negedge clk);
        while (!rsp_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("latency", 64'(k), 64'd2);
        chk("dir_product", rsp_product, exp);
        chk("dir_id", 64'(rsp_id), 64'(id));
        chk("dir_tag", 64'(rsp_tag), 64'(tg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_mplier = '0;
        req_mcand  = '0;
        req_tag    = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        single(2, 32'hFFFF_FFFD, 32'd7,        4'h5, 64'hFFFF_FFFF_FFFF_FFEB);
        single(0, 32'h8000_0000, 32'h8000_0000, 4'hA, 64'h4000_0000_0000_0000);
        single(1, 32'h7FFF_FFFF, 32'h8000_0000, 4'h3, 64'hC000_0000_8000_0000);
        single(3, 32'h0,         32'hFFFF_FFFF, 4'hF, 64'h0);

        run(4, 0, 100, '0);
        run(8, 100, 100, '1);
        run(6, 0, 100, '0);

        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        acc_cnt   = 0;
        run(5, 100, 0, 4'b0011);
        chk("backpressure_accepts", 64'(acc_cnt), 64'd2);
        run(8, 0, 100, '0);

        acc_cnt = 0;
        run(2, 100, 0, 4'b0011);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", 64'(rsp_valid), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        run(6, 100, 100, '1);

        run(400, 60, 70, '1);
        run(12, 0, 100, '0);
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
